stage_fe_prefetch: RTL and testbench
====================================

# stage_fe_prefetch

Parametrised instruction-fetch stage with a prefetch buffer and a valid/ready handshake to decode. It drives a synchronous program memory, queues fetched instructions tagged with their PC, and redirects to an arbitrary target rather than only to address 0. It sits between program memory and the decode stage, and replaces the fixed single-register fetch stage in cores that need backpressure and branch redirects.

## Interface
- `INST_W`, default `` `INST_W `` (32): instruction width.
- `ADDR_W`, default `` `INST_ADDR_W `` (10): program-memory word-address width.
- `DEPTH`, default 4: prefetch FIFO entries. Must be a power of two and ≥2; sustained 1 instr/cycle requires ≥3.
- `RESET_PC`, default 0: PC loaded at reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  fetch enable; gates new memory reads only.
- `redirect`  in  1  discard all queued/in-flight fetches and restart at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  redirect target.
- `progmem_en`  out  1  read strobe.
- `progmem_addr`  out  ADDR_W  read address (always equals PC).
- `progmem_data`  in  INST_W  read data, valid one cycle after the strobe.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_inst`  out  INST_W  head instruction.
- `out_pc`  out  ADDR_W  PC of the head instruction.

## Operation
- Reset values: PC = `RESET_PC`; FIFO empty; in-flight flag = 0; `out_valid` = 0; `progmem_en` = 0; `out_inst`/`out_pc` = 0.
- Issue: `progmem_en = en && !redirect && (count + inflight < DEPTH)`.
  - The slot freed by a pop in the same cycle is not counted.
  - On issue, PC ← PC+1 (mod 2^ADDR_W, so all-ones wraps to 0). The issue PC is held as `inflight_pc`, and `inflight` is set for the next cycle.
- Capture: if `inflight` is set and no redirect occurs this cycle, {`progmem_data`, `inflight_pc`} is pushed at the end of the cycle. A push can never overflow, because the credit check guarantees room.
- Pop: on `out_valid && out_ready`. Push and pop in the same cycle keep `count` unchanged.
- Redirect (highest priority), at the edge that samples it:
  - PC ← `redirect_pc`.
  - FIFO emptied, `inflight` cleared, and returning data from an earlier strobe dropped.
  - No issue and no pop that cycle, even if `out_ready` = 1.
- `en` low: no new issues. An in-flight read is still captured, and the FIFO keeps draining.
- `rst_n` asserted mid-operation: immediate return to the reset values. Any in-flight data is discarded.

## Timing
- Fetch latency: strobe in cycle c, data on `progmem_data` in c+1, pushed at the end of c+1, `out_valid` in c+2.
- After reset release with `en` = 1: the first strobe occurs in the first cycle, with `progmem_addr = RESET_PC`.
- Redirect sampled at edge t: `progmem_addr = redirect_pc` with a strobe in cycle t+1; the first post-redirect `out_valid` is in cycle t+3.
- Steady state (`out_ready` = 1, `DEPTH` ≥ 3): one instruction per cycle, with consecutive PCs.
- With `out_ready` = 0: strobes stop once `count + inflight` = `DEPTH`, and `out_inst`/`out_pc` stay stable while `out_valid` is high.

## Structure
- `defines.vh` supplies `INST_W` and `INST_ADDR_W`; no new global constants are added.
- Sub-module `fetch_fifo`, parametrised by data width and depth:
  - synchronous FIFO with a synchronous `clear` and an asynchronous `rst_n`;
  - entry = {pc, inst};
  - exposes `count` (log2(DEPTH)+1 bits), `empty` and `full`;
  - pointers wrap naturally at `DEPTH`.
- The top level contains the PC, the in-flight tracking, the credit check and the redirect logic.

## Test plan
- Reset release, `en` = 1, `out_ready` = 1, memory word i = 0x1000_0000+i: `out_valid` first rises in cycle 2, then emits PCs 0, 1, 2, … each cycle with matching instructions.
- Backpressure: `out_ready` = 0 from cycle 0 with `DEPTH` = 4: exactly 4 strobes (addresses 0–3), then `progmem_en` = 0. Releasing `out_ready` drains PCs 0–3 in order, and fetching resumes at PC 4.
- Redirect to 0x200 while one read is in flight and the FIFO holds 2 entries: the FIFO empties, the stale data is never output, and the next `out_pc` values are 0x200, 0x201.
- Redirect asserted together with `out_valid && out_ready`: the head is not consumed, the FIFO is empty next cycle, and the target is strobed in cycle t+1.
- Wrap-around: redirect to 2^ADDR_W−2: outputs PCs 0x3FE, 0x3FF, 0x000, 0x001 (`ADDR_W` = 10).
- `rst_n` pulsed low mid-stream with `en` = 0 after release: `out_valid` = 0 and `progmem_en` = 0 immediately. When `en` is raised, the first strobe is at `RESET_PC`.

Source files
------------

// File: rtl/stage_fe_prefetch_pkg.sv
// Shared constants for the prefetching fetch stage.
// Default widths match the core's instruction word and program-memory
// address widths, so an un-parametrised instance drops into the core.
package stage_fe_prefetch_pkg;

  localparam int INST_W_DEF      = 32;  // instruction width
  localparam int INST_ADDR_W_DEF = 10;  // program-memory word-address width
  localparam int DEPTH_DEF       = 4;   // prefetch FIFO entries

  // FIFO counter width for a given depth. The extra bit lets the
  // counter hold DEPTH itself, so "full" can be told apart from "empty".
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stage_fe_prefetch_if.sv
// Program-memory read port and decode-side valid/ready handshake.
// master: the fetch stage. slave: program memory plus decode.
interface stage_fe_prefetch_if
  import stage_fe_prefetch_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int ADDR_W = INST_ADDR_W_DEF
) ();

  // Program-memory side (synchronous read, data one cycle after strobe)
  logic              progmem_en;
  logic [ADDR_W-1:0] progmem_addr;
  logic [INST_W-1:0] progmem_data;

  // Decode side
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output progmem_en,
    output progmem_addr,
    input  progmem_data,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  progmem_en,
    input  progmem_addr,
    output progmem_data,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/stage_fe_prefetch_fetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, synchronous clear,
// asynchronous reset. Each entry is {pc, inst}. The head word is forced
// to zero while the FIFO is empty so the outputs read 0 after reset.
module fetch_fifo
  import stage_fe_prefetch_pkg::*;
#(
  parameter int DATA_W = INST_W_DEF + INST_ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head word; zero when empty so stale storage never reaches decode.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; every entry is written before
  // it can be read, and the empty-gated head hides uninitialised words.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; clear wins over push and pop. Pointers are
  // PTR_W bits wide, so they wrap at DEPTH without extra logic.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stage_fe_prefetch.sv
// Instruction-fetch stage with a prefetch buffer.
// Issues reads to a synchronous program memory whenever the FIFO has a
// free credit, captures the returning word one cycle later tagged with
// its PC, and presents the FIFO head to decode over valid/ready.
// A redirect flushes everything queued or in flight and restarts at an
// arbitrary target. DEPTH must be a power of two and at least 2; a
// depth of 3 or more is needed for one instruction per cycle.
module stage_fe_prefetch
  import stage_fe_prefetch_pkg::*;
#(
  parameter int              INST_W   = INST_W_DEF,
  parameter int              ADDR_W   = INST_ADDR_W_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  stage_fe_prefetch_if.master  bus
);

  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;

  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic [CNT_W:0]     credit_used;
  logic               credit_ok;

  logic               issue;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Credits: queued entries plus the read still in flight. A slot freed
  // by a pop this cycle is deliberately not counted, which keeps the
  // issue path independent of out_ready.
  always_comb begin
    credit_used = {1'b0, count} + (CNT_W + 1)'(inflight);
    credit_ok   = (credit_used < (CNT_W + 1)'(DEPTH)) && !full;
  end

  // Issue, capture and pop decisions; redirect suppresses all three.
  // rst_n is folded into issue so the strobe drops the moment reset is
  // asserted rather than at the next edge.
  always_comb begin
    issue = rst_n && en && !redirect && credit_ok;
    push  = inflight && !redirect;
    pop   = !empty && bus.out_ready && !redirect;
  end

  assign bus.progmem_en   = issue;
  assign bus.progmem_addr = pc;

  // PC and in-flight tracking; redirect has priority over issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (push),
    .push_data ({inflight_pc, bus.progmem_data}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign bus.out_valid = !empty;
  assign bus.out_pc    = head[INST_W +: ADDR_W];
  assign bus.out_inst  = head[INST_W-1:0];

endmodule

// File: tb/tb_stage_fe_prefetch.sv
// Directed bench for stage_fe_prefetch (defaults: 32-bit inst, 10-bit
// address, DEPTH 4, RESET_PC 0). Program memory word i = 0x1000_0000+i.
// Inputs change just after the falling edge; outputs are checked 1 ns
// later, well away from the rising edge.
module tb_stage_fe_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [9:0]  redirect_pc;

  int checks = 0;
  int errors = 0;

  stage_fe_prefetch_if #(.INST_W(32), .ADDR_W(10)) bus ();

  stage_fe_prefetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous program memory model.
  always @(posedge clk) begin
    if (bus.progmem_en) bus.progmem_data <= 32'h1000_0000 + 32'(bus.progmem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.out_ready = 1'b1;
    bus.progmem_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_pm_en", bus.progmem_en, 0);
    check("rst_inst", bus.out_inst, 0);
    check("rst_pc", bus.out_pc, 0);

    // Steady stream: first strobe in cycle 0, out_valid in cycle 2
    @(negedge clk); rst_n = 1'b1; en = 1'b1; #1;
    check("c0_pm_en", bus.progmem_en, 1);
    check("c0_addr", bus.progmem_addr, 0);
    check("c0_valid", bus.out_valid, 0);
    @(negedge clk); #1;
    check("c1_addr", bus.progmem_addr, 1);
    check("c1_valid", bus.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("stream_valid", bus.out_valid, 1);
      check("stream_pc", bus.out_pc, i);
      check("stream_inst", bus.out_inst, word(i));
    end

    // Mid-stream reset with en low: outputs drop immediately
    @(negedge clk); en = 1'b0; rst_n = 1'b0; #1;
    check("mrst_valid", bus.out_valid, 0);
    check("mrst_pm_en", bus.progmem_en, 0);
    check("mrst_pc", bus.out_pc, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("idle_pm_en", bus.progmem_en, 0);
    @(negedge clk); #1;
    check("idle_valid", bus.out_valid, 0);

    // Backpressure: exactly 4 strobes at 0..3, then none
    @(negedge clk); en = 1'b1; bus.out_ready = 1'b0; #1;
    check("bp_pm_en_0", bus.progmem_en, 1);
    check("bp_addr_0", bus.progmem_addr, 0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); #1;
      check("bp_pm_en", bus.progmem_en, (k < 4) ? 1 : 0);
      if (k < 4) check("bp_addr", bus.progmem_addr, k);
    end
    check("bp_hold_valid", bus.out_valid, 1);
    check("bp_hold_pc", bus.out_pc, 0);
    check("bp_hold_inst", bus.out_inst, word(0));

    // Release: drain 0..3, fetch resumes at 4 one cycle after first pop
    @(negedge clk); bus.out_ready = 1'b1; #1;
    check("drain_pc_0", bus.out_pc, 0);
    check("drain_pm_en_0", bus.progmem_en, 0);
    @(negedge clk); #1;
    check("drain_pc_1", bus.out_pc, 1);
    check("resume_pm_en", bus.progmem_en, 1);
    check("resume_addr", bus.progmem_addr, 4);
    for (int j = 2; j < 6; j++) begin
      @(negedge clk); #1;
      check("drain_valid", bus.out_valid, 1);
      check("drain_pc", bus.out_pc, j);
      check("drain_inst", bus.out_inst, word(j));
    end

    // Redirect with one read in flight and two queued entries
    @(negedge clk); rst_n = 1'b0; en = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1; en = 1'b1; bus.out_ready = 1'b0; #1;
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirect_pc = 10'h200; #1;
    check("rd1_pre_valid", bus.out_valid, 1);
    check("rd1_pre_pc", bus.out_pc, 0);
    check("rd1_pm_en", bus.progmem_en, 0);
    @(negedge clk); redirect = 1'b0; bus.out_ready = 1'b1; #1;
    check("rd1_t1_valid", bus.out_valid, 0);
    check("rd1_t1_pm_en", bus.progmem_en, 1);
    check("rd1_t1_addr", bus.progmem_addr, 10'h200);
    @(negedge clk); #1;
    check("rd1_t2_valid", bus.out_valid, 0);
    check("rd1_t2_addr", bus.progmem_addr, 10'h201);
    @(negedge clk); #1;
    check("rd1_t3_valid", bus.out_valid, 1);
    check("rd1_t3_pc", bus.out_pc, 10'h200);
    check("rd1_t3_inst", bus.out_inst, word(10'h200));
    @(negedge clk); #1;
    check("rd1_t4_pc", bus.out_pc, 10'h201);

    // Redirect coinciding with a pop, target near the top of memory
    @(negedge clk); redirect = 1'b1; redirect_pc = 10'h3FE; #1;
    check("rd2_pre_valid", bus.out_valid, 1);
    check("rd2_pre_pc", bus.out_pc, 10'h202);
    check("rd2_pm_en", bus.progmem_en, 0);
    @(negedge clk); redirect = 1'b0; #1;
    check("rd2_t1_valid", bus.out_valid, 0);
    check("rd2_t1_pm_en", bus.progmem_en, 1);
    check("rd2_t1_addr", bus.progmem_addr, 10'h3FE);
    @(negedge clk); #1;
    check("rd2_t2_addr", bus.progmem_addr, 10'h3FF);
    @(negedge clk); #1;
    check("wrap_valid", bus.out_valid, 1);
    check("wrap_pc_0", bus.out_pc, 10'h3FE);
    check("wrap_inst_0", bus.out_inst, word(10'h3FE));
    @(negedge clk); #1;
    check("wrap_pc_1", bus.out_pc, 10'h3FF);
    @(negedge clk); #1;
    check("wrap_pc_2", bus.out_pc, 10'h000);
    check("wrap_inst_2", bus.out_inst, word(0));
    @(negedge clk); #1;
    check("wrap_pc_3", bus.out_pc, 10'h001);
    check("wrap_inst_3", bus.out_inst, word(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
